// File: rtl/arbiter_pkg.sv
// Shared types and defaults for the arbiter requester front end.
package arbiter_pkg;

   localparam int N_REQ       = 2;
   localparam int BURST_W_DEF = 4;
   localparam int WAIT_W_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      OWN     = 2'd2,
      RELEASE = 2'd3
   } req_state_e;

   function automatic logic is_active(input req_state_e s);
      return (s == REQ) || (s == OWN);
   endfunction

endpackage

// File: rtl/arbiter_req_client.sv
// Per-client request FSM: latches a burst, requests until all beats
// are granted, then releases for one cycle and pulses done.
module arbiter_req_client
   import arbiter_pkg::*;
#(
   parameter int BURST_W = BURST_W_DEF,
   parameter int WAIT_W  = WAIT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [BURST_W-1:0] len,
   input  logic               grant,
   output req_state_e         state,
   output logic               request,
   output logic               busy,
   output logic               done,
   output logic               timeout,
   output logic               revoke
);

   localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

   req_state_e         state_d;
   logic [BURST_W-1:0] len_q;
   logic [BURST_W-1:0] len_c;
   logic [BURST_W-1:0] beat_cnt;
   logic [BURST_W-1:0] beat_nxt;
   logic [WAIT_W-1:0]  wait_cnt;

   // A zero-length burst still needs one granted beat.
   assign len_c    = (len == '0) ? BURST_W'(1) : len;
   assign beat_nxt = beat_cnt + BURST_W'(1);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (start) state_d = REQ;
         REQ: begin
            if (grant)
               state_d = (len_q == BURST_W'(1)) ? RELEASE : OWN;
         end
         OWN: begin
            if (!grant || beat_nxt == len_q)
               state_d = RELEASE;
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      request = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      revoke  = 1'b0;
      request = is_active(state);
      busy    = (state != IDLE);
      done    = (state == RELEASE);
      revoke  = (state == OWN) && !grant;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_q    <= '0;
         beat_cnt <= '0;
         wait_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  len_q    <= len_c;
                  beat_cnt <= '0;
                  wait_cnt <= '0;
               end
            end
            REQ: begin
               if (grant) begin
                  beat_cnt <= BURST_W'(1);
               end else if (wait_cnt != WAIT_MAX) begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
                  if (wait_cnt == WAIT_MAX - WAIT_W'(1))
                     timeout <= 1'b1;
               end
            end
            OWN: begin
               if (grant) beat_cnt <= beat_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/arbiter_requester.sv
// Two-client requester front end with grant protocol checking.
// Error flags are sticky until reset.
module arbiter_requester
   import arbiter_pkg::*;
#(
   parameter int BURST_W = BURST_W_DEF,
   parameter int WAIT_W  = WAIT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         start,
   input  logic [N_REQ*BURST_W-1:0] len,
   input  logic [N_REQ-1:0]         grant,
   output logic [N_REQ-1:0]         request,
   output logic [N_REQ-1:0]         busy,
   output logic [N_REQ-1:0]         done,
   output logic [N_REQ-1:0]         timeout,
   output logic                     err_onehot,
   output logic                     err_spurious,
   output logic                     err_revoke
);

   req_state_e       st [N_REQ];
   logic [N_REQ-1:0] active;
   logic [N_REQ-1:0] revoke;
   logic             onehot_hit;
   logic             spur_hit;

   for (genvar g = 0; g < N_REQ; g++) begin : g_client
      arbiter_req_client #(
         .BURST_W (BURST_W),
         .WAIT_W  (WAIT_W)
      ) u_client (
         .clk     (clk),
         .rst     (rst),
         .start   (start[g]),
         .len     (len[g*BURST_W +: BURST_W]),
         .grant   (grant[g]),
         .state   (st[g]),
         .request (request[g]),
         .busy    (busy[g]),
         .done    (done[g]),
         .timeout (timeout[g]),
         .revoke  (revoke[g])
      );
      assign active[g] = is_active(st[g]);
   end

   // Grant is only legal toward a client that is currently requesting.
   assign onehot_hit = (grant == '1);
   assign spur_hit   = |(grant & ~active);

   always_ff @(posedge clk) begin
      if (rst) begin
         err_onehot   <= 1'b0;
         err_spurious <= 1'b0;
         err_revoke   <= 1'b0;
      end else begin
         if (onehot_hit) err_onehot   <= 1'b1;
         if (spur_hit)   err_spurious <= 1'b1;
         if (|revoke)    err_revoke   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_arbiter_requester.sv
// Directed bench for arbiter_requester with hand-computed expectations.
module tb_arbiter_requester;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] start;
   logic [7:0] len;
   logic [1:0] grant;
   logic [1:0] request;
   logic [1:0] busy;
   logic [1:0] done;
   logic [1:0] timeout;
   logic       err_onehot;
   logic       err_spurious;
   logic       err_revoke;

   int errors = 0;
   int checks = 0;

   arbiter_requester dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .len          (len),
      .grant        (grant),
      .request      (request),
      .busy         (busy),
      .done         (done),
      .timeout      (timeout),
      .err_onehot   (err_onehot),
      .err_spurious (err_spurious),
      .err_revoke   (err_revoke)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = '0; grant = '0; len = '0;
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = '0; grant = '0; len = '0;
      cyc();
      cyc();
      checks++;
      if ({request, busy, done, timeout, err_onehot, err_spurious,
           err_revoke} !== 11'b0) begin
         errors++;
         $display("FAIL reset_outs act=%b exp=0", {request, busy, done,
                  timeout, err_onehot, err_spurious, err_revoke});
      end
      rst = 1'b0;
   endtask

   task automatic test_single_burst();
      do_reset();
      start = 2'b01; len = 8'h03;
      cyc();
      start = 2'b00;
      checks++;
      if (request !== 2'b01) begin
         errors++; $display("FAIL t1_req_rise act=%b exp=01", request);
      end
      cyc();
      cyc();
      grant = 2'b01;
      cyc();
      cyc();
      checks++;
      if (request !== 2'b01 || done !== 2'b00) begin
         errors++;
         $display("FAIL t1_mid act req=%b done=%b exp 01/00", request, done);
      end
      cyc();
      grant = 2'b00;
      checks++;
      if (request !== 2'b00 || done !== 2'b01) begin
         errors++;
         $display("FAIL t1_end act req=%b done=%b exp 00/01", request, done);
      end
      cyc();
      checks++;
      if (done !== 2'b00 || busy !== 2'b00) begin
         errors++;
         $display("FAIL t1_idle act done=%b busy=%b exp 00/00", done, busy);
      end
      checks++;
      if ({err_onehot, err_spurious, err_revoke} !== 3'b000) begin
         errors++;
         $display("FAIL t1_errs act=%b exp=000",
                  {err_onehot, err_spurious, err_revoke});
      end
   endtask

   task automatic test_dual_start();
      do_reset();
      start = 2'b11; len = 8'h11;
      cyc();
      start = 2'b00;
      checks++;
      if (request !== 2'b11) begin
         errors++; $display("FAIL t2_both_req act=%b exp=11", request);
      end
      grant = 2'b10;
      cyc();
      checks++;
      if (request !== 2'b01 || done !== 2'b10) begin
         errors++;
         $display("FAIL t2_c1 act req=%b done=%b exp 01/10", request, done);
      end
      grant = 2'b01;
      cyc();
      checks++;
      if (request !== 2'b00 || done !== 2'b01) begin
         errors++;
         $display("FAIL t2_c0 act req=%b done=%b exp 00/01", request, done);
      end
      grant = 2'b00;
      cyc();
      checks++;
      if ({err_onehot, err_spurious, err_revoke} !== 3'b000) begin
         errors++;
         $display("FAIL t2_errs act=%b exp=000",
                  {err_onehot, err_spurious, err_revoke});
      end
   endtask

   task automatic test_timeout();
      do_reset();
      start = 2'b01; len = 8'h01;
      cyc();
      start = 2'b00;
      for (int i = 1; i <= 15; i++) begin
         cyc();
         if (i == 14) begin
            checks++;
            if (timeout !== 2'b00) begin
               errors++; $display("FAIL t3_early act=%b exp=00", timeout);
            end
         end
      end
      checks++;
      if (timeout !== 2'b01 || request !== 2'b01) begin
         errors++;
         $display("FAIL t3_hit act to=%b req=%b exp 01/01", timeout, request);
      end
      cyc();
      checks++;
      if (timeout !== 2'b01 || request !== 2'b01) begin
         errors++;
         $display("FAIL t3_hold act to=%b req=%b exp 01/01", timeout, request);
      end
      grant = 2'b01;
      cyc();
      grant = 2'b00;
      checks++;
      if (done !== 2'b01 || request !== 2'b00) begin
         errors++;
         $display("FAIL t3_done act done=%b req=%b exp 01/00", done, request);
      end
      cyc();
   endtask

   task automatic test_grant_errors();
      do_reset();
      grant = 2'b10;
      cyc();
      grant = 2'b00;
      checks++;
      if (err_spurious !== 1'b1 || request !== 2'b00) begin
         errors++;
         $display("FAIL t4_spur act sp=%b req=%b exp 1/00",
                  err_spurious, request);
      end
      checks++;
      if (err_onehot !== 1'b0) begin
         errors++; $display("FAIL t4_oh_pre act=%b exp=0", err_onehot);
      end
      start = 2'b11; len = 8'h11;
      cyc();
      start = 2'b00;
      grant = 2'b11;
      cyc();
      grant = 2'b00;
      checks++;
      if (err_onehot !== 1'b1 || done !== 2'b11) begin
         errors++;
         $display("FAIL t4_onehot act oh=%b done=%b exp 1/11",
                  err_onehot, done);
      end
      cyc();
   endtask

   task automatic test_revoke();
      do_reset();
      start = 2'b01; len = 8'h04;
      cyc();
      start = 2'b00;
      grant = 2'b01;
      cyc();
      cyc();
      checks++;
      if (err_revoke !== 1'b0 || request !== 2'b01) begin
         errors++;
         $display("FAIL t5_pre act rv=%b req=%b exp 0/01", err_revoke, request);
      end
      grant = 2'b00;
      cyc();
      checks++;
      if (err_revoke !== 1'b1 || request !== 2'b00 || done !== 2'b01) begin
         errors++;
         $display("FAIL t5_revoke act rv=%b req=%b done=%b exp 1/00/01",
                  err_revoke, request, done);
      end
      cyc();
      checks++;
      if (done !== 2'b00) begin
         errors++; $display("FAIL t5_done_once act=%b exp=00", done);
      end
   endtask

   task automatic test_reset_mid_and_restart();
      start = 2'b01; len = 8'h05;
      cyc();
      start = 2'b00;
      grant = 2'b01;
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      grant = 2'b00;
      checks++;
      if ({request, busy, done, timeout, err_onehot, err_spurious,
           err_revoke} !== 11'b0) begin
         errors++;
         $display("FAIL t6_rst_mid act=%b exp=0", {request, busy, done,
                  timeout, err_onehot, err_spurious, err_revoke});
      end
      start = 2'b01; len = 8'h03;
      cyc();
      start = 2'b00;
      grant = 2'b01;
      cyc();
      start = 2'b01; len = 8'h01;
      cyc();
      start = 2'b00;
      checks++;
      if (done !== 2'b00 || busy !== 2'b01) begin
         errors++;
         $display("FAIL t6_ignore act done=%b busy=%b exp 00/01", done, busy);
      end
      cyc();
      grant = 2'b00;
      checks++;
      if (done !== 2'b01 || request !== 2'b00) begin
         errors++;
         $display("FAIL t6_len_kept act done=%b req=%b exp 01/00",
                  done, request);
      end
      cyc();
      checks++;
      if (busy !== 2'b00 || done !== 2'b00) begin
         errors++;
         $display("FAIL t6_idle act busy=%b done=%b exp 00/00", busy, done);
      end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_dual_start();
      test_timeout();
      test_grant_errors();
      test_revoke();
      test_reset_mid_and_restart();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
